// File: rtl/prt_pkg.sv
// Shared types and defaults for the PRT read arbiter: slot/table sizing,
// arbiter FSM states and the registered output beat.
package prt_pkg;

    localparam int Index_Size = 1;
    localparam int Table_Size = 2;
    localparam int DATA_SIZE  = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_RD,
        ST_WAIT,
        ST_DONE
    } arb_state_t;

    typedef struct packed {
        logic                 valid;
        logic [DATA_SIZE-1:0] data;
        logic                 last;
        logic                 err;
    } PRTReadOutput;

    // Terminal beat for a frame that could not be read.
    function automatic PRTReadOutput err_beat();
        PRTReadOutput b;
        b.valid = 1'b1;
        b.data  = '0;
        b.last  = 1'b1;
        b.err   = 1'b1;
        return b;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after ptr (wrapping);
// ptr moves one past the granted requester when the grant is taken.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    input  logic               advance,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_id,
    output logic               grant_valid
);

    logic [ID_W-1:0] ptr;
    int              idx;

    // Scan from the farthest offset back to ptr so the nearest requester wins.
    always_comb begin
        grant       = '0;
        grant_id    = '0;
        grant_valid = 1'b0;
        idx         = 0;
        for (int off = NUM_REQ - 1; off >= 0; off--) begin
            idx = (int'(ptr) + off) % NUM_REQ;
            if (req[idx]) begin
                grant       = '0;
                grant[idx]  = 1'b1;
                grant_id    = ID_W'(idx);
                grant_valid = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr <= '0;
        end else if (advance && grant_valid) begin
            ptr <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
        end
    end

endmodule

// File: rtl/prt_read_arbiter.sv
// Shares the PRT read port among NUM_REQ egress requesters and streams the
// granted slot's bytes to one registered output. Optional: PRT_RD_TIMEOUT_EN.
module prt_read_arbiter
    import prt_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int INDEX_SIZE  = Index_Size,
    parameter int TABLE_SIZE  = Table_Size,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*INDEX_SIZE-1:0] req_slot,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [TABLE_SIZE-1:0]         prt_slot_valid,
    output logic                          prt_start_rd_en,
    output logic [INDEX_SIZE-1:0]         prt_start_rd_slot,
    output logic                          prt_rd_en,
    input  logic                          prt_rd_valid,
    input  logic [7:0]                    prt_rd_data,
    input  logic                          prt_rd_last,
    output logic                          prt_inv_en,
    output logic [INDEX_SIZE-1:0]         prt_inv_slot,
    output logic                          out_valid,
    output logic [7:0]                    out_data,
    output logic                          out_last,
    output logic                          out_err,
    output logic [$clog2(NUM_REQ)-1:0]    out_req_id,
    input  logic                          out_ready
);

    localparam int ID_W = $clog2(NUM_REQ);

    arb_state_t            state;
    logic [ID_W-1:0]       cur_id;
    logic [INDEX_SIZE-1:0] cur_slot;
    PRTReadOutput          obuf;

    logic [NUM_REQ-1:0]    grant;
    logic [ID_W-1:0]       grant_id;
    logic                  grant_vld;
    logic [INDEX_SIZE-1:0] grant_slot;
    logic                  grant_slot_ok;
    logic                  take;
    logic                  out_fire;
    logic                  timeout_hit;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr (
        .clk         (clk),
        .reset       (reset),
        .req         (req_valid),
        .advance     (take),
        .grant       (grant),
        .grant_id    (grant_id),
        .grant_valid (grant_vld)
    );

    assign take          = (state == ST_IDLE) && grant_vld;
    assign req_ready     = take ? grant : '0;
    assign grant_slot    = req_slot[grant_id*INDEX_SIZE +: INDEX_SIZE];
    assign grant_slot_ok = (int'(grant_slot) < TABLE_SIZE) && prt_slot_valid[grant_slot];
    assign out_fire      = obuf.valid && out_ready;

    // A byte read is only attempted when the output register will be free to take it.
    assign prt_start_rd_en   = (state == ST_START);
    assign prt_start_rd_slot = cur_slot;
    assign prt_rd_en         = (state == ST_RD) && (!obuf.valid || out_ready);

    assign out_valid  = obuf.valid;
    assign out_data   = obuf.data;
    assign out_last   = obuf.last;
    assign out_err    = obuf.err;
    assign out_req_id = cur_id;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            cur_id   <= '0;
            cur_slot <= '0;
            obuf     <= '0;
        end else begin
            if (out_fire) obuf <= '0;
            unique case (state)
                ST_IDLE: begin
                    if (take) begin
                        cur_id   <= grant_id;
                        cur_slot <= grant_slot;
                        if (grant_slot_ok) begin
                            state <= ST_START;
                        end else begin
                            obuf  <= err_beat();
                            state <= ST_DONE;
                        end
                    end
                end
                ST_START: state <= ST_RD;
                ST_RD: begin
                    if (prt_rd_en) state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (prt_rd_valid) begin
                        obuf  <= '{valid: 1'b1, data: prt_rd_data, last: prt_rd_last, err: 1'b0};
                        state <= prt_rd_last ? ST_DONE : ST_RD;
                    end else if (timeout_hit) begin
                        obuf  <= err_beat();
                        state <= ST_DONE;
                    end else begin
                        state <= ST_RD;
                    end
                end
                ST_DONE: begin
                    if (out_fire || !obuf.valid) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef PRT_RD_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0]      stall_cnt;
    logic                  inv_en;
    logic [INDEX_SIZE-1:0] inv_slot;

    // Fires on the TIMEOUT_CYC-th consecutive empty attempt.
    assign timeout_hit  = (state == ST_WAIT) && !prt_rd_valid &&
                          (stall_cnt == CNT_W'(TIMEOUT_CYC - 1));
    assign prt_inv_en   = inv_en;
    assign prt_inv_slot = inv_slot;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= '0;
            inv_en    <= 1'b0;
            inv_slot  <= '0;
        end else begin
            inv_en <= timeout_hit;
            if (timeout_hit) inv_slot <= cur_slot;
            if (take || timeout_hit || ((state == ST_WAIT) && prt_rd_valid)) begin
                stall_cnt <= '0;
            end else if (state == ST_WAIT) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
        end
    end
`else
    assign timeout_hit  = 1'b0;
    assign prt_inv_en   = 1'b0;
    assign prt_inv_slot = '0;
`endif

endmodule

// File: tb/tb_prt_read_arbiter.sv
// Directed self-checking bench for prt_read_arbiter with a behavioural PRT
// responder; the timeout scenario runs only when PRT_RD_TIMEOUT_EN is defined.
module tb_prt_read_arbiter;

    localparam int NUM_REQ    = 4;
    localparam int INDEX_SIZE = 1;
    localparam int TABLE_SIZE = 2;
`ifdef PRT_RD_TIMEOUT_EN
    localparam int TIMEOUT_CYC = 8;
`else
    localparam int TIMEOUT_CYC = 1024;
`endif

    logic                          clk = 1'b0;
    logic                          reset = 1'b0;
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*INDEX_SIZE-1:0] req_slot;
    logic [NUM_REQ-1:0]            req_ready;
    logic [TABLE_SIZE-1:0]         prt_slot_valid;
    logic                          prt_start_rd_en;
    logic [INDEX_SIZE-1:0]         prt_start_rd_slot;
    logic                          prt_rd_en;
    logic                          prt_rd_valid;
    logic [7:0]                    prt_rd_data;
    logic                          prt_rd_last;
    logic                          prt_inv_en;
    logic [INDEX_SIZE-1:0]         prt_inv_slot;
    logic                          out_valid;
    logic [7:0]                    out_data;
    logic                          out_last;
    logic                          out_err;
    logic [1:0]                    out_req_id;
    logic                          out_ready;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    prt_read_arbiter #(
        .NUM_REQ     (NUM_REQ),
        .INDEX_SIZE  (INDEX_SIZE),
        .TABLE_SIZE  (TABLE_SIZE),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .req_valid         (req_valid),
        .req_slot          (req_slot),
        .req_ready         (req_ready),
        .prt_slot_valid    (prt_slot_valid),
        .prt_start_rd_en   (prt_start_rd_en),
        .prt_start_rd_slot (prt_start_rd_slot),
        .prt_rd_en         (prt_rd_en),
        .prt_rd_valid      (prt_rd_valid),
        .prt_rd_data       (prt_rd_data),
        .prt_rd_last       (prt_rd_last),
        .prt_inv_en        (prt_inv_en),
        .prt_inv_slot      (prt_inv_slot),
        .out_valid         (out_valid),
        .out_data          (out_data),
        .out_last          (out_last),
        .out_err           (out_err),
        .out_req_id        (out_req_id),
        .out_ready         (out_ready)
    );

    // PRT responder: answers an attempt one cycle later; entries are {last, data}.
    logic [8:0] prt_q[$];
    int         fail_left = 0;
    int         miss_cnt  = 0;
    logic       model_en;
    logic [8:0] model_e;

    initial begin
        prt_rd_valid = 1'b0;
        prt_rd_data  = 8'h00;
        prt_rd_last  = 1'b0;
        forever begin
            @(negedge clk);
            model_en = prt_rd_en && reset;
            @(posedge clk);
            #1;
            prt_rd_valid = 1'b0;
            prt_rd_data  = 8'h00;
            prt_rd_last  = 1'b0;
            if (model_en) begin
                if (fail_left > 0) begin
                    fail_left--;
                    miss_cnt++;
                end else if (prt_q.size() > 0) begin
                    model_e      = prt_q.pop_front();
                    prt_rd_valid = 1'b1;
                    prt_rd_last  = model_e[8];
                    prt_rd_data  = model_e[7:0];
                end else begin
                    miss_cnt++;
                end
            end
        end
    end

    // Monitor: beats are {data, last, err, id}.
    int          cyc = 0;
    logic [11:0] beats[$];
    int          beat_cyc[$];
    int          grant_ids[$];
    int          grant_beats[$];
    int          grant_cyc[$];
    int          n_start, n_rd, n_inv, n_rd_full, n_grant_bad;
    logic [INDEX_SIZE-1:0] inv_slot_seen;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (reset) begin
            if (prt_start_rd_en) n_start++;
            if (prt_rd_en) n_rd++;
            if (prt_rd_en && out_valid && !out_ready) n_rd_full++;
            if (prt_inv_en) begin
                n_inv++;
                inv_slot_seen = prt_inv_slot;
            end
            if (req_ready != '0) begin
                if (!$onehot(req_ready)) n_grant_bad++;
                for (int i = 0; i < NUM_REQ; i++) if (req_ready[i]) grant_ids.push_back(i);
                grant_beats.push_back(beats.size());
                grant_cyc.push_back(cyc);
            end
            if (out_valid && out_ready) begin
                beats.push_back({out_data, out_last, out_err, out_req_id});
                beat_cyc.push_back(cyc);
            end
        end
    end

    task automatic clear_mon();
        beats.delete(); beat_cyc.delete();
        grant_ids.delete(); grant_beats.delete(); grant_cyc.delete();
        n_start = 0; n_rd = 0; n_inv = 0; n_rd_full = 0; n_grant_bad = 0;
        inv_slot_seen = '0;
        miss_cnt = 0;
    endtask

    task automatic do_reset();
        reset     = 1'b0;
        req_valid = '0;
        req_slot  = '0;
        out_ready = 1'b1;
        prt_q.delete();
        fail_left = 0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        clear_mon();
    endtask

    task automatic wait_grants(input int n, input int budget);
        for (int k = 0; k < budget; k++) begin
            if (grant_ids.size() >= n) break;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_beats(input int n, input int budget);
        for (int k = 0; k < budget; k++) begin
            if (beats.size() >= n) break;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        req_valid      = '0;
        req_slot       = '0;
        out_ready      = 1'b1;
        prt_slot_valid = 2'b11;
        reset          = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({out_valid, out_last, out_err, out_data, out_req_id} !== 13'd0)
            $display("FAIL reset_out got=%b want=0", {out_valid, out_last, out_err, out_data, out_req_id});
        else n_pass++;
        n_checks++;
        if ({prt_start_rd_en, prt_rd_en, prt_inv_en} !== 3'b000)
            $display("FAIL reset_strobes got=%b want=000", {prt_start_rd_en, prt_rd_en, prt_inv_en});
        else n_pass++;
        reset = 1'b1;
        clear_mon();
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (req_ready !== 4'b0000 || n_start != 0)
            $display("FAIL reset_idle got=req_ready %b starts %0d want=0000 0", req_ready, n_start);
        else n_pass++;
    endtask

    task automatic test_single_frame();
        logic [11:0] exp [3];
        logic [11:0] got;
        clear_mon();
        prt_slot_valid = 2'b11;
        prt_q          = '{9'h0A1, 9'h0B2, 9'h1C3};
        req_slot       = '0;
        req_valid      = 4'b0001;
        wait_grants(1, 20);
        req_valid = '0;
        wait_beats(3, 50);
        repeat (4) @(posedge clk);
        #1;
        exp = '{{8'hA1, 1'b0, 1'b0, 2'd0}, {8'hB2, 1'b0, 1'b0, 2'd0}, {8'hC3, 1'b1, 1'b0, 2'd0}};
        n_checks++;
        if (beats.size() != 3) $display("FAIL single_count got=%0d want=3", beats.size());
        else n_pass++;
        for (int k = 0; k < 3; k++) begin
            got = (k < beats.size()) ? beats[k] : 12'hxxx;
            n_checks++;
            if (got !== exp[k]) $display("FAIL single_beat%0d got=%h want=%h", k, got, exp[k]);
            else n_pass++;
        end
        n_checks++;
        if (grant_ids.size() != 1 || grant_ids[0] != 0)
            $display("FAIL single_grant got=%0d grants want=1 grant of id 0", grant_ids.size());
        else n_pass++;
        n_checks++;
        if (n_start != 1 || n_rd != 3)
            $display("FAIL single_strobes got=start %0d rd %0d want=start 1 rd 3", n_start, n_rd);
        else n_pass++;
        n_checks++;
        if (beats.size() != 3 || beat_cyc[0] - grant_cyc[0] != 4)
            $display("FAIL single_latency got=%0d want=4", (beats.size() > 0) ? beat_cyc[0] - grant_cyc[0] : -1);
        else n_pass++;
        n_checks++;
        if (beats.size() != 3 || beat_cyc[2] - beat_cyc[0] != 4)
            $display("FAIL single_rate got=%0d want=4", (beats.size() == 3) ? beat_cyc[2] - beat_cyc[0] : -1);
        else n_pass++;
    endtask

    task automatic test_round_robin();
        int exp_ids [5];
        int got;
        int bad_order;
        logic [11:0] gb;
        do_reset();
        prt_slot_valid = 2'b11;
        prt_q          = '{9'h110, 9'h111, 9'h112, 9'h113, 9'h114};
        req_slot       = '0;
        req_valid      = 4'b1111;
        wait_grants(5, 200);
        req_valid = '0;
        wait_beats(5, 50);
        repeat (4) @(posedge clk);
        #1;
        exp_ids = '{0, 1, 2, 3, 0};
        n_checks++;
        if (grant_ids.size() != 5) $display("FAIL rr_count got=%0d want=5", grant_ids.size());
        else n_pass++;
        for (int k = 0; k < 5; k++) begin
            got = (k < grant_ids.size()) ? grant_ids[k] : -1;
            n_checks++;
            if (got != exp_ids[k]) $display("FAIL rr_grant%0d got=%0d want=%0d", k, got, exp_ids[k]);
            else n_pass++;
        end
        for (int k = 0; k < 5; k++) begin
            gb = (k < beats.size()) ? beats[k] : 12'hxxx;
            n_checks++;
            if (gb !== {8'h10 + 8'(k), 1'b1, 1'b0, 2'(exp_ids[k])})
                $display("FAIL rr_beat%0d got=%h want=%h", k, gb, {8'h10 + 8'(k), 1'b1, 1'b0, 2'(exp_ids[k])});
            else n_pass++;
        end
        bad_order = 0;
        for (int k = 0; k < grant_beats.size(); k++) if (grant_beats[k] != k) bad_order++;
        n_checks++;
        if (bad_order != 0 || n_grant_bad != 0)
            $display("FAIL rr_serial got=overlaps %0d non-onehot %0d want=0 0", bad_order, n_grant_bad);
        else n_pass++;
    endtask

    task automatic test_retry();
        logic [11:0] got;
        clear_mon();
        prt_slot_valid = 2'b11;
        fail_left      = 5;
        prt_q          = '{9'h0D4, 9'h1E5};
        req_slot       = '0;
        req_valid      = 4'b0010;
        wait_grants(1, 20);
        req_valid = '0;
        wait_beats(2, 80);
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (beats.size() != 2) $display("FAIL retry_count got=%0d want=2", beats.size());
        else n_pass++;
        got = (beats.size() > 0) ? beats[0] : 12'hxxx;
        n_checks++;
        if (got !== {8'hD4, 1'b0, 1'b0, 2'd1}) $display("FAIL retry_beat0 got=%h want=%h", got, {8'hD4, 4'b0001});
        else n_pass++;
        got = (beats.size() > 1) ? beats[1] : 12'hxxx;
        n_checks++;
        if (got !== {8'hE5, 1'b1, 1'b0, 2'd1}) $display("FAIL retry_beat1 got=%h want=%h", got, {8'hE5, 4'b1001});
        else n_pass++;
        n_checks++;
        if (n_rd != 7 || miss_cnt != 5)
            $display("FAIL retry_attempts got=rd %0d miss %0d want=rd 7 miss 5", n_rd, miss_cnt);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        int stable;
        logic [11:0] got;
        clear_mon();
        prt_slot_valid = 2'b11;
        prt_q          = '{9'h031, 9'h032, 9'h033, 9'h134};
        out_ready      = 1'b0;
        req_slot       = 4'b1000;
        req_valid      = 4'b1000;
        wait_grants(1, 20);
        req_valid = '0;
        for (int k = 0; k < 20; k++) begin
            if (out_valid) break;
            @(posedge clk);
            #1;
        end
        stable = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            if (out_valid && out_data == 8'h31 && !out_last) stable++;
        end
        n_checks++;
        if (stable != 10) $display("FAIL bp_hold got=%0d stable cycles want=10", stable);
        else n_pass++;
        n_checks++;
        if (n_rd != 1 || n_rd_full != 0)
            $display("FAIL bp_no_read got=rd %0d rd_while_full %0d want=1 0", n_rd, n_rd_full);
        else n_pass++;
        out_ready = 1'b1;
        wait_beats(4, 50);
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (beats.size() != 4) $display("FAIL bp_count got=%0d want=4", beats.size());
        else n_pass++;
        for (int k = 0; k < 4; k++) begin
            got = (k < beats.size()) ? beats[k] : 12'hxxx;
            n_checks++;
            if (got !== {8'h31 + 8'(k), (k == 3), 1'b0, 2'd3})
                $display("FAIL bp_beat%0d got=%h want=%h", k, got, {8'h31 + 8'(k), (k == 3), 1'b0, 2'd3});
            else n_pass++;
        end
    endtask

    task automatic test_invalid_slot();
        logic [11:0] got;
        clear_mon();
        prt_slot_valid = 2'b01;
        req_slot       = 4'b0100;
        req_valid      = 4'b0100;
        wait_grants(1, 20);
        req_valid = '0;
        wait_beats(1, 20);
        repeat (4) @(posedge clk);
        #1;
        n_checks++;
        if (beats.size() != 1) $display("FAIL inv_count got=%0d want=1", beats.size());
        else n_pass++;
        got = (beats.size() > 0) ? beats[0] : 12'hxxx;
        n_checks++;
        if (got !== {8'h00, 1'b1, 1'b1, 2'd2}) $display("FAIL inv_beat got=%h want=%h", got, {8'h00, 4'b1110});
        else n_pass++;
        n_checks++;
        if (n_start != 0 || n_rd != 0)
            $display("FAIL inv_no_access got=start %0d rd %0d want=0 0", n_start, n_rd);
        else n_pass++;
        n_checks++;
        if (beats.size() != 1 || beat_cyc[0] - grant_cyc[0] != 1)
            $display("FAIL inv_latency got=%0d want=1", (beats.size() > 0) ? beat_cyc[0] - grant_cyc[0] : -1);
        else n_pass++;
    endtask

`ifdef PRT_RD_TIMEOUT_EN
    task automatic test_timeout();
        logic [11:0] got;
        do_reset();
        prt_slot_valid = 2'b11;
        fail_left      = 1000;
        req_slot       = 4'b0001;
        req_valid      = 4'b0001;
        wait_grants(1, 20);
        req_valid = '0;
        wait_beats(1, 100);
        repeat (3) @(posedge clk);
        #1;
        got = (beats.size() > 0) ? beats[0] : 12'hxxx;
        n_checks++;
        if (got !== {8'h00, 1'b1, 1'b1, 2'd0}) $display("FAIL to_beat got=%h want=%h", got, {8'h00, 4'b1100});
        else n_pass++;
        n_checks++;
        if (n_inv != 1 || inv_slot_seen !== 1'b1)
            $display("FAIL to_inv got=pulses %0d slot %0d want=1 1", n_inv, inv_slot_seen);
        else n_pass++;
        n_checks++;
        if (n_rd != 8) $display("FAIL to_attempts got=%0d want=8", n_rd);
        else n_pass++;
        fail_left = 0;
    endtask
`endif

    task automatic test_reset_mid_frame();
        clear_mon();
        prt_slot_valid = 2'b11;
        prt_q          = '{9'h055, 9'h166};
        out_ready      = 1'b0;
        req_slot       = '0;
        req_valid      = 4'b0001;
        wait_grants(1, 20);
        req_valid = '0;
        for (int k = 0; k < 20; k++) begin
            if (out_valid) break;
            @(posedge clk);
            #1;
        end
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h55)
            $display("FAIL mid_pre got=%b %h want=1 55", out_valid, out_data);
        else n_pass++;
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        n_checks++;
        if ({out_valid, out_last, out_err, out_data, out_req_id} !== 13'd0)
            $display("FAIL mid_reset_out got=%b want=0", {out_valid, out_last, out_err, out_data, out_req_id});
        else n_pass++;
        n_checks++;
        if ({prt_start_rd_en, prt_rd_en, prt_inv_en, req_ready} !== 7'd0)
            $display("FAIL mid_reset_strobes got=%b want=0", {prt_start_rd_en, prt_rd_en, prt_inv_en, req_ready});
        else n_pass++;
        @(posedge clk);
        #1;
        reset     = 1'b1;
        out_ready = 1'b1;
        prt_q.delete();
        clear_mon();
        repeat (5) @(posedge clk);
        #1;
        n_checks++;
        if (n_start != 0 || n_rd != 0 || out_valid !== 1'b0)
            $display("FAIL mid_after got=start %0d rd %0d valid %b want=0 0 0", n_start, n_rd, out_valid);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_round_robin();
        test_retry();
        test_backpressure();
        test_invalid_slot();
`ifdef PRT_RD_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=completion");
        $fatal(1, "watchdog expired");
    end

endmodule
